seq_shift_add_mult: RTL and testbench
=====================================

Name: seq_shift_add_mult

Overview:
Sequential radix-2 shift-and-add multiplier. It consumes the 1-bit full_adder cell: a WIDTH-long ripple chain of full_adder instances forms the partial-product accumulator. It produces one WIDTH x WIDTH -> 2*WIDTH product per operation over WIDTH+1 cycles, using a start/done handshake. It is the area-optimised baseline that the fast multiplier variants are benchmarked against.

Parameters:
- WIDTH, 32, operand width in bits. Legal values are 4..64; the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a multiply; sampled on a clk edge
- in1  input  WIDTH  multiplicand; sampled only on an accepted start
- in2  input  WIDTH  multiplier; sampled only on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; product is valid in this cycle
- product  output  2*WIDTH  result register; holds its value until the next result is written

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0. Internal accumulator, multiplicand, multiplier and counter registers are all 0.
- Reset mid-operation: the operation is abandoned. The next cycle shows IDLE with all outputs at their reset values. No done pulse is emitted.
- FSM has three states: IDLE, CALC, FIN.
- IDLE: if start=1, latch in1 into mcand and in2 into mplier. Clear acc_hi and the carry, load count=WIDTH-1, go to CALC. Otherwise stay.
- CALC, one step per cycle:
  - The full_adder chain computes {c, s} = acc_hi + (mplier[0] ? mcand : 0), with cin=0 into bit 0.
  - The {c, s, mplier} register is then shifted right by 1: acc_hi <= {c, s[WIDTH-1:1]}, mplier <= {s[0], mplier[WIDTH-1:1]}.
  - When count=0, go to FIN and write product <= {acc_hi, mplier} post-step. Otherwise count decrements.
- FIN: done=1 for exactly this cycle. If start=1 here, it is accepted exactly as in IDLE (back-to-back ops, next state CALC). Otherwise go to IDLE.
- busy=1 in CALC only; busy=0 in IDLE and FIN.
- start while busy=1 is ignored; in1/in2 changes have no effect.
- Latency: start accepted at edge E0, WIDTH CALC cycles follow, and done=1 in the cycle after edge E(WIDTH). That is, the product is visible WIDTH+1 cycles after start is asserted. Throughput is one op per WIDTH+1 cycles.
- Arithmetic:
  - Unsigned by default. The full 2*WIDTH result is exact, so overflow is impossible.
  - The carry out of the chain's MSB is retained in the shift (the c bit); it is never dropped.
- product holds across IDLE and changes only on the CALC->FIN write or on reset.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - in1/in2 are two's complement.
  - At accept, the magnitudes |in1| and |in2| are latched, and neg = in1[MSB] ^ in2[MSB] is latched using the same XOR as the sign-bit cell.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned.
  - On the CALC->FIN write, product = neg ? -(result) : result, using a two's complement negate within the same cycle. Latency is unchanged.
  - Signed 0 result is always written as 0.
- Undefined: purely unsigned operation; no sign logic is synthesized.

Test Plan:
- Reset, then start with in1=3, in2=5 (WIDTH=32) -> busy high for 32 cycles; done pulses once 33 cycles after start; product=0x000000000000000F.
- in1=0xFFFFFFFF, in2=0xFFFFFFFF (unsigned build) -> product=0xFFFFFFFE00000001; the MSB carry is preserved.
- During CALC, pulse start with in1=7, in2=7 -> ignored; the first op completes with its original result; no extra done pulse.
- Assert rst at cycle 10 of CALC -> next cycle busy=0, done=0, product=0. A new start with 2*9 then yields 18 after 33 cycles.
- Hold start=1 through FIN with new operands 6*7 -> no IDLE cycle; the second done arrives 33 cycles after the first; product=42.
- With SEQ_MULT_SIGNED_EN, in1=-3, in2=5 -> product=0xFFFFFFFFFFFFFFF1. Also in1=0x80000000, in2=0x80000000 -> product=0x4000000000000000.

Source files
------------

// File: rtl/seq_shift_add_mult.sv
// Radix-2 sequential shift-and-add multiplier built on a ripple chain of full_adder cells.
// Optional two's complement operation is enabled with the SEQ_MULT_SIGNED_EN macro.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seq_shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               last_s;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH:0]     carry_s;
  logic [WIDTH-1:0]   op1_s;
  logic [WIDTH-1:0]   op2_s;
  logic [2*WIDTH-1:0] result_s;
  logic [2*WIDTH-1:0] final_s;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] product_r;

  // Partial-product adder: ripple chain of full_adder cells
  assign carry_s[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (acc_hi_r[i]),
      .b    (addend_s[i]),
      .cin  (carry_s[i]),
      .s    (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end

  // Multiplicand gated by the current multiplier LSB
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  // Post-step value of the {c, s, mplier} shift register; the MSB carry is kept
  assign result_s = {carry_s[WIDTH], sum_s, mplier_r[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_r;
  logic neg_s;

  // Operands are latched as magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned
  always_comb begin
    op1_s = in1;
    op2_s = in2;
    if (in1[WIDTH-1]) begin
      op1_s = {WIDTH{1'b0}} - in1;
    end else begin
      op1_s = in1;
    end
    if (in2[WIDTH-1]) begin
      op2_s = {WIDTH{1'b0}} - in2;
    end else begin
      op2_s = in2;
    end
  end

  assign neg_s = in1[WIDTH-1] ^ in2[WIDTH-1];

  // Sign register captured with the operands
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_r <= 1'b0;
    end else if (accept_s) begin
      neg_r <= neg_s;
    end else begin
      neg_r <= neg_r;
    end
  end

  // Negating zero yields zero, so a signed zero result is always written as 0
  always_comb begin
    final_s = result_s;
    if (neg_r) begin
      final_s = {(2*WIDTH){1'b0}} - result_s;
    end else begin
      final_s = result_s;
    end
  end
`else
  assign op1_s   = in1;
  assign op2_s   = in2;
  assign final_s = result_s;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; FIN accepts a new start exactly like IDLE
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE, FIN: begin
        if (start) begin
          state_next_s = CALC;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (count_r == {CW{1'b0}}) begin
          state_next_s = FIN;
          last_s       = 1'b1;
        end else begin
          state_next_s = CALC;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_r  <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        mcand_r  <= op1_s;
        mplier_r <= op2_s;
        acc_hi_r <= {WIDTH{1'b0}};
        count_r  <= CNT_MAX;
      end else if (state_r == CALC) begin
        acc_hi_r <= {carry_s[WIDTH], sum_s[WIDTH-1:1]};
        mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
        if (last_s) begin
          count_r <= count_r;
        end else begin
          count_r <= count_r - CNT_ONE;
        end
      end else begin
        acc_hi_r <= acc_hi_r;
        mplier_r <= mplier_r;
        count_r  <= count_r;
      end
      if (last_s) begin
        product_r <= final_s;
      end else begin
        product_r <= product_r;
      end
      busy_r <= (state_next_s == CALC);
      done_r <= (state_next_s == FIN);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult (WIDTH=32); follows SEQ_MULT_SIGNED_EN when defined.
module tb_seq_shift_add_mult;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  // Reference: full-precision product computed with plain arithmetic
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
`ifdef SEQ_MULT_SIGNED_EN
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
`else
    sa = {{W{1'b0}}, a};
    sb = {{W{1'b0}}, b};
`endif
    return sa * sb;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands for one edge; returns at the negedge just after the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
  endtask

  // Cycles counted from the accepting edge (k=1 is the first cycle after it)
  task automatic wait_done(input int k0, output int k, output int busy_cnt);
    k = k0;
    busy_cnt = 0;
    while (!done && k < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int k;
    int bc;
    start_op(a, b);
    wait_done(1, k, bc);
    check({name, " latency"}, 64'(k), 64'(W + 1));
    check({name, " busy cycles"}, 64'(bc), 64'(W));
    check({name, " product"}, product, exp);
    @(negedge clk);
    check({name, " done one cycle"}, {63'd0, done}, 64'd0);
    check({name, " product holds"}, product, exp);
  endtask

  vec_t vecs[$];
  int   k;
  int   bc;
  int   extra;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;

`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{32'd3,          32'd5,          64'h0000_0000_0000_000F});
    vecs.push_back('{32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1});
    vecs.push_back('{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001});
    vecs.push_back('{32'd0,          32'hFFFF_FFFF,  64'h0000_0000_0000_0000});
    vecs.push_back('{32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000});
`else
    vecs.push_back('{32'd3,          32'd5,          64'h0000_0000_0000_000F});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'd0,          32'hFFFF_FFFF,  64'h0000_0000_0000_0000});
    vecs.push_back('{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF});
    vecs.push_back('{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000});
    vecs.push_back('{32'h0000_FFFF,  32'h0001_0001,  64'h0000_0000_FFFF_FFFF});
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset product", product, 64'd0);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // start pulsed mid-CALC must be ignored
    start_op(32'd11, 32'd13);
    repeat (4) @(negedge clk);
    start = 1'b1;
    in1   = 32'd7;
    in2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, k, bc);
    check("ignore latency", 64'(k), 64'(W + 1));
    check("ignore product", product, 64'd143);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignore no extra done", 64'(extra), 64'd0);

    // synchronous reset at cycle 10 of CALC abandons the operation
    start_op(32'd100, 32'd200);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst product", product, 64'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midrst no done", 64'(extra), 64'd0);
    run_op("after rst", 32'd2, 32'd9, 64'd18);

    // start held through FIN: back-to-back with no IDLE cycle
    start_op(32'd4, 32'd5);
    wait_done(1, k, bc);
    check("b2b first product", product, 64'd20);
    start = 1'b1;
    in1   = 32'd6;
    in2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy after FIN", {63'd0, busy}, 64'd1);
    wait_done(1, k, bc);
    check("b2b spacing", 64'(k), 64'(W + 1));
    check("b2b second product", product, 64'd42);
    @(negedge clk);

    // randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = {1'b1, {(W-1){1'b0}}};
      if (i % 8 == 1) rb = '1;
      run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
